seg7_disp_arb: RTL and testbench

Round-robin arbiter that shares the single 4-digit seven-segment display among `N_REQ` requesters. It grants one requester at a time and latches that requester's 16-bit hex word. It holds the word on the display for a fixed `HOLD_CYCLES` window and pulses the display's digit-scan clear at each ownership change. It sits between the measurement sources and the seven-segment display controller. It drives that controller's 16-bit value input and `clr` input.

---
 rtl/seg7_pkg.sv | 9 +
 rtl/seg7_rr_pick.sv | 29 ++
 rtl/seg7_disp_arb.sv | 79 +++++++
 tb/tb_seg7_disp_arb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment display sharing blocks
//   seg7_arb_state_e : arbiter state (IDLE, HOLD)
//   SEG7_WORD_W      : width of one display word (4 hex digits)
//   BLANK_WORD       : word with every digit code B, which the display renders with all segments off
package seg7_pkg;
   typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} seg7_arb_state_e;
   localparam int SEG7_WORD_W = 16;
   localparam logic [SEG7_WORD_W-1:0] BLANK_WORD = 16'hBBBB;
endpackage

// File: rtl/seg7_rr_pick.sv
// seg7_rr_pick: combinational round-robin picker
//   req   in  N_REQ : request vector, already masked by the caller
//   last  in  IW    : index of the previous owner; search starts at last+1
//   valid out 1     : some request is set
//   idx   out IW    : winning index (holds last when nothing is requested)
module seg7_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic             valid,
   output logic [IW-1:0]    idx
);
   logic [IW-1:0] c;
   // Scan farthest offset first so the nearest requester after last overwrites the result.
   always_comb begin
      valid = 1'b0;
      idx = last;
      c = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         c = IW'((int'(last) + i) % N_REQ);
         if (req[c]) begin
            valid = 1'b1;
            idx = c;
         end
      end
   end
endmodule

// File: rtl/seg7_disp_arb.sv
// seg7_disp_arb: round-robin arbiter sharing one 4-digit seven-segment display among N_REQ requesters
//   clk     in  1          : clock, rising edge
//   rst_i   in  1          : asynchronous active-high reset
//   req_i   in  N_REQ      : level requests
//   data_i  in  N_REQ*16   : requester k's word at [16k+15:16k]
//   ack_o   out N_REQ      : one-cycle grant pulse, one-hot or zero
//   owner_o out clog2(N)   : current or last owner
//   busy_o  out 1          : hold window running
//   x_o     out 16         : word to the display controller
//   clr_o   out 1          : one-cycle scan restart, coincident with each x_o change
module seg7_disp_arb
   import seg7_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic                         clk,
   input  logic                         rst_i,
   input  logic [N_REQ-1:0]             req_i,
   input  logic [N_REQ*SEG7_WORD_W-1:0] data_i,
   output logic [N_REQ-1:0]             ack_o,
   output logic [$clog2(N_REQ)-1:0]     owner_o,
   output logic                         busy_o,
   output logic [SEG7_WORD_W-1:0]       x_o,
   output logic                         clr_o
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   seg7_arb_state_e        state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [N_REQ-1:0]       ack_q, ack_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [SEG7_WORD_W-1:0] x_q, x_d;
   logic                   clr_q, clr_d;
   logic [SEG7_WORD_W-1:0] words [N_REQ];
   logic                   win_valid, grant;
   logic [IW-1:0]          win_idx;
   for (genvar g = 0; g < N_REQ; g++) begin : g_word
      assign words[g] = data_i[g*SEG7_WORD_W +: SEG7_WORD_W];
   end
   // The ack mask keeps a requester that has not yet dropped its request from winning again.
   seg7_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req_i & ~ack_q),
      .last  (owner_q),
      .valid (win_valid),
      .idx   (win_idx)
   );
   always_comb begin
      grant = win_valid && (state_q == IDLE || cnt_q == '0);
      ack_d = grant ? (N_REQ'(1) << win_idx) : '0;
      clr_d = grant;
      x_d = grant ? words[win_idx] : x_q;
      owner_d = grant ? win_idx : owner_q;
      cnt_d = grant ? CW'(HOLD_CYCLES - 1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
      state_d = grant ? HOLD : (cnt_q == '0 ? IDLE : state_q);
   end
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ack_q <= '0;
         owner_q <= IW'(N_REQ - 1);
         x_q <= BLANK_WORD;
         clr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ack_q <= ack_d;
         owner_q <= owner_d;
         x_q <= x_d;
         clr_q <= clr_d;
      end
   end
   assign ack_o = ack_q;
   assign owner_o = owner_q;
   assign busy_o = (state_q == HOLD);
   assign x_o = x_q;
   assign clr_o = clr_q;
endmodule

// File: tb/tb_seg7_disp_arb.sv
// tb_seg7_disp_arb: table-driven and directed checks of seg7_disp_arb with N_REQ=4, HOLD_CYCLES=4 (and 1)
module tb_seg7_disp_arb;
   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [63:0] data;
      logic [23:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [3:0]  req_i = '0, req1_i = '0;
   logic [63:0] data_i = '0;
   logic [3:0]  ack_o, ack1_o;
   logic [1:0]  owner_o, owner1_o;
   logic        busy_o, busy1_o, clr_o, clr1_o;
   logic [15:0] x_o, x1_o;
   int checks = 0;
   int errors = 0;
   vec_t tv[$];

   localparam logic [63:0] RR_DATA = 64'h3333_2222_1111_0000;
   localparam logic [63:0] SG_DATA = 64'h3333_1234_1111_0000;

   seg7_disp_arb #(.N_REQ(4), .HOLD_CYCLES(4)) u_dut (
      .clk(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
      .ack_o(ack_o), .owner_o(owner_o), .busy_o(busy_o), .x_o(x_o), .clr_o(clr_o)
   );
   seg7_disp_arb #(.N_REQ(4), .HOLD_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_i(rst_i), .req_i(req1_i), .data_i(RR_DATA),
      .ack_o(ack1_o), .owner_o(owner1_o), .busy_o(busy1_o), .x_o(x1_o), .clr_o(clr1_o)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pk(logic [3:0] a, logic c, logic [15:0] x, logic [1:0] o, logic b);
      return {a, c, x, o, b};
   endfunction

   function automatic vec_t mk(logic r, logic [3:0] q, logic [63:0] d, logic [23:0] e);
      vec_t v;
      v.rst = r; v.req = q; v.data = d; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [23:0] RST_EXP = {4'b0000, 1'b0, 16'hBBBB, 2'd3, 1'b0};

   initial begin
      // single grant to requester 2, request dropped after ack
      tv.push_back(mk(0, 4'b0100, SG_DATA, pk(4'b0100, 1, 16'h1234, 2, 1)));
      tv.push_back(mk(0, 4'b0000, SG_DATA, pk(4'b0000, 0, 16'h1234, 2, 1)));
      tv.push_back(mk(0, 4'b0000, SG_DATA, pk(4'b0000, 0, 16'h1234, 2, 1)));
      tv.push_back(mk(0, 4'b0000, SG_DATA, pk(4'b0000, 0, 16'h1234, 2, 1)));
      tv.push_back(mk(0, 4'b0000, SG_DATA, pk(4'b0000, 0, 16'h1234, 2, 0)));
      tv.push_back(mk(0, 4'b0000, SG_DATA, pk(4'b0000, 0, 16'h1234, 2, 0)));
      tv.push_back(mk(1, 4'b0000, RR_DATA, RST_EXP));
      // all four requesting: grants 0,1,2,3,0 every 4 cycles, no idle gap
      for (int i = 0; i <= 16; i++) begin
         logic [1:0] o;
         o = 2'((i / 4) % 4);
         tv.push_back(mk(0, 4'b1111, RR_DATA,
            pk((i % 4 == 0) ? (4'b0001 << o) : 4'b0000, i % 4 == 0, {4{2'b00, o}}, o, 1)));
      end

      rst_i = 1'b1;
      step();
      chk("reset_state", pk(ack_o, clr_o, x_o, owner_o, busy_o), RST_EXP);
      rst_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_no_req", pk(ack_o, clr_o, x_o, owner_o, busy_o), RST_EXP);
      end

      for (int i = 0; i < tv.size(); i++) begin
         rst_i = tv[i].rst;
         req_i = tv[i].req;
         data_i = tv[i].data;
         step();
         chk($sformatf("vec%0d", i), pk(ack_o, clr_o, x_o, owner_o, busy_o), tv[i].exp);
      end

      // HOLD_CYCLES=1: alternating grants between 0 and 1
      req_i = '0;
      req1_i = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("hold1_ack%0d", i), {ack1_o, clr1_o, owner1_o}, {(i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1, 2'(i % 2)});
      end
      req1_i = '0;

      // rotation after owner 2: pending 0 and 3, 3 wins first
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      data_i = RR_DATA;
      req_i = 4'b0100;
      step();
      chk("rot_g2", pk(ack_o, clr_o, x_o, owner_o, busy_o), pk(4'b0100, 1, 16'h2222, 2, 1));
      req_i = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rot_hold2", {ack_o, clr_o, busy_o}, {4'b0000, 1'b0, 1'b1});
      end
      step();
      chk("rot_g3", pk(ack_o, clr_o, x_o, owner_o, busy_o), pk(4'b1000, 1, 16'h3333, 3, 1));
      req_i = 4'b0001;
      for (int i = 0; i < 3; i++) step();
      step();
      chk("rot_g0", pk(ack_o, clr_o, x_o, owner_o, busy_o), pk(4'b0001, 1, 16'h0000, 0, 1));
      req_i = '0;

      // mid-hold reset aborts asynchronously; first grant afterwards is requester 0
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      req_i = 4'b0100;
      step();
      chk("mid_g2", {ack_o, owner_o}, {4'b0100, 2'd2});
      req_i = 4'b0101;
      step();
      chk("mid_busy", {ack_o, busy_o}, {4'b0000, 1'b1});
      rst_i = 1'b1;
      #1;
      chk("mid_async_rst", pk(ack_o, clr_o, x_o, owner_o, busy_o), RST_EXP);
      step();
      rst_i = 1'b0;
      step();
      chk("mid_post_g0", pk(ack_o, clr_o, x_o, owner_o, busy_o), pk(4'b0001, 1, 16'h0000, 0, 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
